// File: rtl/multiplier_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: controller state encoding
// and the default operand width.
package multiplier_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/multiplier_arbiter_if.sv
// Requester/response bundle between two requesters and the arbiter.
//   req0_*/req1_* : valid/ready request channels carrying unsigned operands
//   rsp0_valid/rsp1_valid : one-cycle result strobes, rsp_r is the shared product
//   busy : arbiter is in the middle of an operation
// master = requester side, slave = arbiter side.
interface multiplier_arbiter_if
  import multiplier_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp0_valid;
  logic               rsp1_valid;
  logic [2*WIDTH-1:0] rsp_r;
  logic               busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_r, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_r, busy
  );

endinterface

// File: rtl/multiplier_iterative.sv
// Shift-and-add unsigned multiplier, one partial product per clock.
//   clk       : clock
//   valid_in  : start a new product (restarts any operation in flight)
//   a, b      : unsigned operands, sampled with valid_in
//   valid_out : one-cycle strobe, WIDTH cycles after valid_in
//   r         : 2*WIDTH-bit product, valid with valid_out
// Deliberately has no reset: valid_in always reloads every register, so any
// leftover state from before a reset can only produce a stale valid_out.
module multiplier_iterative
  import multiplier_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               valid_in,
  output logic               valid_out,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;     // steps remaining, 0 = idle

  always_ff @(posedge clk) begin
    valid_out <= 1'b0;
    if (valid_in) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      // last step: acc holds the full product after this edge
      if (cnt == CW'(1)) valid_out <= 1'b1;
    end
  end

  assign r = acc;

endmodule

// File: rtl/multiplier_arbiter.sv
// Two-requester round-robin front end for a single iterative multiplier.
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : requester/response bundle (slave side)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; ready is granted combinationally
// ISSUE   | valid_in pulsed to the multiplier with latched operands
// WAIT    | waiting for multiplier valid_out, result registered on it
// RESPOND | one-cycle rsp strobe to the granted requester
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  multiplier_arbiter_if.slave  bus
);

  arb_state_e         state;
  logic               ptr;        // requester favoured on contention
  logic               grant;      // id of the operation in flight
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               mul_valid_in;
  logic               mul_valid_out;
  logic [2*WIDTH-1:0] mul_r;
  logic               rsp0_q;
  logic               rsp1_q;
  logic [2*WIDTH-1:0] rsp_r_q;
  logic               busy_q;
  logic               idle;
  logic               grant0;
  logic               grant1;

  // Ready is masked during reset so nothing can be accepted while the
  // registers are being forced.
  assign idle   = (state == IDLE) && !reset;
  assign grant0 = idle && bus.req0_valid && (!bus.req1_valid || !ptr);
  assign grant1 = idle && bus.req1_valid && (!bus.req0_valid ||  ptr);

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp_r      = rsp_r_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      grant        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      mul_valid_in <= 1'b0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      rsp_r_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            grant        <= grant1;
            op_a         <= grant1 ? bus.req1_a : bus.req0_a;
            op_b         <= grant1 ? bus.req1_b : bus.req0_b;
            mul_valid_in <= 1'b1;
            busy_q       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          mul_valid_in <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          // valid_out outside WAIT belongs to an abandoned operation
          if (mul_valid_out) begin
            rsp_r_q <= mul_r;
            rsp0_q  <= !grant;
            rsp1_q  <= grant;
            state   <= RESPOND;
          end
        end
        RESPOND: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          ptr    <= !grant;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  multiplier_iterative #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .valid_in  (mul_valid_in),
    .valid_out (mul_valid_out),
    .a         (op_a),
    .b         (op_b),
    .r         (mul_r)
  );

endmodule

// File: tb/tb_multiplier_arbiter.sv
module tb_multiplier_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multiplier_arbiter_if #(.WIDTH(W)) bus ();

  multiplier_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state: who was served last (1 => requester 0 favoured).
  bit last_served = 1'b1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v0, input bit v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_a = a0;
    bus.req0_b = b0;
    bus.req1_a = a1;
    bus.req1_b = b1;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return $urandom;
  endfunction

  // One complete operation, entered and left at a sample point in IDLE.
  // hold keeps both valids asserted through the operation.
  task automatic op(input bit v0, input bit v1,
                    input logic [W-1:0] a0, input logic [W-1:0] b0,
                    input logic [W-1:0] a1, input logic [W-1:0] b1,
                    input bit hold);
    int n;
    bit g;
    bit ok;
    logic prev_vo;
    logic [2*W-1:0] exp;

    drive(v0, v1, a0, b0, a1, b1);
    #1;
    n = 0;
    while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    check1("accept_in_first_idle", n == 0, 1'b1);
    if (n >= 8) return;

    g = (v0 && v1) ? ~last_served : v1;
    check1("ready0", bus.req0_ready, ~g);
    check1("ready1", bus.req1_ready, g);
    exp = g ? 64'(a1) * 64'(b1) : 64'(a0) * 64'(b0);

    @(negedge clk); #1;
    if (!hold) drive(1'b0, 1'b0, a0, b0, a1, b1);
    check1("valid_in_issue", dut.mul_valid_in, 1'b1);
    check1("busy_issue", bus.busy, 1'b1);

    @(negedge clk); #1;
    check1("valid_in_one_cycle", dut.mul_valid_in, 1'b0);

    ok = 1'b1;
    prev_vo = 1'b0;
    n = 0;
    while (!(bus.rsp0_valid || bus.rsp1_valid) && n < 100) begin
      if (bus.req0_ready || bus.req1_ready || !bus.busy) ok = 1'b0;
      prev_vo = dut.mul_valid_out;
      @(negedge clk); #1;
      n++;
    end
    check1("rsp_within_bound", n < 100, 1'b1);
    check1("no_ready_busy_during_op", ok, 1'b1);
    if (n >= 100) return;
    check1("rsp_after_valid_out", prev_vo, 1'b1);
    check1("rsp0_valid", bus.rsp0_valid, ~g);
    check1("rsp1_valid", bus.rsp1_valid, g);
    check64("rsp_r", bus.rsp_r, exp);
    last_served = g;

    @(negedge clk); #1;
    check1("busy_idle", bus.busy, 1'b0);
    check1("rsp_one_cycle", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_served = 1'b1;
    #1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bit ok;
    bit v0, v1, hold;

    // Reset state, with requester 0 already asserting valid.
    drive(1'b1, 1'b0, 32'd1, 32'd1, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    check1("rst_ready0", bus.req0_ready, 1'b0);
    check1("rst_ready1", bus.req1_ready, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_rsp0", bus.rsp0_valid, 1'b0);
    check1("rst_rsp1", bus.rsp1_valid, 1'b0);
    check64("rst_rsp_r", bus.rsp_r, 64'd0);
    check1("rst_valid_in", dut.mul_valid_in, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    reset = 1'b0;
    last_served = 1'b1;

    // Single requester 0, accepted in first IDLE cycle after reset.
    op(1'b1, 1'b0, 32'd3, 32'd5, '0, '0, 1'b0);

    // Contention right after reset: requester 0 first, then 1.
    apply_reset();
    op(1'b1, 1'b1, 32'd2, 32'd7, 32'd4, 32'd9, 1'b1);
    op(1'b1, 1'b1, 32'd2, 32'd7, 32'd4, 32'd9, 1'b0);

    // Both held valid for six operations: grants alternate.
    for (int i = 0; i < 6; i++)
      op(1'b1, 1'b1, 32'(i + 1), 32'(i + 10), 32'(i + 100), 32'(i + 1000), i < 5);

    // Maximum operands, no truncation.
    op(1'b0, 1'b1, '0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Reset mid-WAIT abandons the operation.
    drive(1'b1, 1'b0, 32'd100, 32'd100, '0, '0);
    #1;
    check1("mid_reset_accept", bus.req0_ready, 1'b1);
    @(negedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (5) @(negedge clk);
    #1;
    check1("mid_reset_busy_before", bus.busy, 1'b1);
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    check1("mid_reset_ready0", bus.req0_ready, 1'b0);
    check1("mid_reset_busy", bus.busy, 1'b0);
    check64("mid_reset_rsp_r", bus.rsp_r, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    last_served = 1'b1;
    ok = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) ok = 1'b0;
    end
    check1("no_stale_response", ok, 1'b1);
    op(1'b0, 1'b1, '0, '0, 32'd6, 32'd7, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1000; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = 1'($urandom_range(0, 1));
      op(v0, v1, rnd_operand(), rnd_operand(), rnd_operand(), rnd_operand(), hold);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
